// File: rtl/mpt_plb_lookup_stage.sv
// PLB lookup stage: fully-associative cache of MPT permissions keyed by {sdid, ppn}.
// Hits return allow/deny on port 0, misses forward the request to the walker on port 1.
module mpt_plb_lookup_stage #(
   parameter int unsigned PLB_ENTRIES      = 8,
   parameter int unsigned ID_WIDTH         = 4,
   parameter int unsigned PPN_WIDTH        = 20,
   parameter int unsigned SDID_WIDTH       = 6,
   parameter int unsigned SLAVE_DATA_WIDTH = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  logic                          stage_slave_valid_i,
   output logic                          stage_slave_ready_o,
   input  logic [SLAVE_DATA_WIDTH-1:0]   stage_slave_data_i,
   output logic [1:0]                    stage_master_valid_o,
   input  logic [1:0]                    stage_master_ready_i,
   output logic [2*SLAVE_DATA_WIDTH-1:0] stage_master_data_o,
   input  logic                          refill_valid_i,
   input  logic [SDID_WIDTH-1:0]         refill_sdid_i,
   input  logic [PPN_WIDTH-1:0]          refill_ppn_i,
   input  logic [2:0]                    refill_perm_i
);

   localparam int unsigned IDX_W = $clog2(PLB_ENTRIES);
   localparam int unsigned TAG_W = SDID_WIDTH + PPN_WIDTH;

   logic [PLB_ENTRIES-1:0] ent_valid;
   logic [TAG_W-1:0]       ent_tag  [PLB_ENTRIES];
   logic [2:0]             ent_perm [PLB_ENTRIES];
   logic [IDX_W-1:0]       rep_ptr;

   logic [1:0]                    out_valid;
   logic [2*SLAVE_DATA_WIDTH-1:0] out_data;

   logic [ID_WIDTH-1:0] req_id;
   logic [TAG_W-1:0]    req_tag;
   logic [1:0]          req_acc;
   logic                hit;
   logic [2:0]          hit_perm;
   logic                allow;

   logic [TAG_W-1:0] ref_tag;
   logic             ref_match;
   logic             ref_free;
   logic [IDX_W-1:0] ref_match_idx;
   logic [IDX_W-1:0] ref_free_idx;
   logic [IDX_W-1:0] ref_idx;
   logic             ref_we;

   logic out_take;
   logic accept;

   assign req_id  = stage_slave_data_i[ID_WIDTH-1:0];
   assign req_tag = stage_slave_data_i[ID_WIDTH +: TAG_W];
   assign req_acc = stage_slave_data_i[ID_WIDTH+TAG_W +: 2];
   assign ref_tag = {refill_sdid_i, refill_ppn_i};

   // Tag compare against registered contents; descending scan gives lowest index priority.
   always_comb begin
      hit      = 1'b0;
      hit_perm = '0;
      for (int i = PLB_ENTRIES - 1; i >= 0; i--) begin
         if (ent_valid[i] && (ent_tag[i] == req_tag)) begin
            hit      = 1'b1;
            hit_perm = ent_perm[i];
         end
      end
   end

   always_comb begin
      allow = 1'b0;
      case (req_acc)
         2'b00:   allow = hit_perm[0];
         2'b01:   allow = hit_perm[1];
         2'b10:   allow = hit_perm[2];
         default: allow = 1'b0;
      endcase
   end

   // Refill target: existing tag, else lowest invalid entry, else replacement pointer.
   always_comb begin
      ref_match     = 1'b0;
      ref_free      = 1'b0;
      ref_match_idx = '0;
      ref_free_idx  = '0;
      for (int i = PLB_ENTRIES - 1; i >= 0; i--) begin
         if (ent_valid[i] && (ent_tag[i] == ref_tag)) begin
            ref_match     = 1'b1;
            ref_match_idx = IDX_W'(i);
         end
         if (!ent_valid[i]) begin
            ref_free     = 1'b1;
            ref_free_idx = IDX_W'(i);
         end
      end
      ref_idx = ref_match ? ref_match_idx : (ref_free ? ref_free_idx : rep_ptr);
      ref_we  = refill_valid_i & ~flush_i & ~rst_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         ent_valid <= '0;
         rep_ptr   <= '0;
      end else if (refill_valid_i) begin
         ent_valid[ref_idx] <= 1'b1;
         if (!ref_match && !ref_free) begin
            rep_ptr <= rep_ptr + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (ref_we) begin
         ent_tag[ref_idx]  <= ref_tag;
         ent_perm[ref_idx] <= refill_perm_i;
      end
   end

   // Only the port that currently holds the result can release the output register.
   assign out_take            = (out_valid[0] & stage_master_ready_i[0]) |
                                (out_valid[1] & stage_master_ready_i[1]);
   assign stage_slave_ready_o = ~(|out_valid) | out_take;
   assign accept              = stage_slave_valid_i & stage_slave_ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid <= '0;
         out_data  <= '0;
      end else if (accept) begin
         if (hit) begin
            out_valid <= 2'b01;
            out_data  <= {SLAVE_DATA_WIDTH'(0), SLAVE_DATA_WIDTH'({allow, req_id})};
         end else begin
            out_valid <= 2'b10;
            out_data  <= {stage_slave_data_i, SLAVE_DATA_WIDTH'(0)};
         end
      end else if (out_take) begin
         out_valid <= '0;
      end
   end

   assign stage_master_valid_o = out_valid;
   assign stage_master_data_o  = out_data;

endmodule

// File: tb/tb_mpt_plb_lookup_stage.sv
// Directed bench for mpt_plb_lookup_stage: miss/hit paths, replacement, stall, flush, refill update.
module tb_mpt_plb_lookup_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic [1:0]  m_valid;
   logic [1:0]  m_ready;
   logic [63:0] m_data;
   logic        r_valid;
   logic [5:0]  r_sdid;
   logic [19:0] r_ppn;
   logic [2:0]  r_perm;

   int passed = 0;
   int total  = 0;

   mpt_plb_lookup_stage dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .flush_i              (flush),
      .stage_slave_valid_i  (s_valid),
      .stage_slave_ready_o  (s_ready),
      .stage_slave_data_i   (s_data),
      .stage_master_valid_o (m_valid),
      .stage_master_ready_i (m_ready),
      .stage_master_data_o  (m_data),
      .refill_valid_i       (r_valid),
      .refill_sdid_i        (r_sdid),
      .refill_ppn_i         (r_ppn),
      .refill_perm_i        (r_perm)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [1:0] acc, input logic [5:0] sdid,
                                      input logic [19:0] ppn, input logic [3:0] id);
      return {acc, sdid, ppn, id};
   endfunction

   function automatic logic [63:0] hitw(input logic allow, input logic [3:0] id);
      return {32'h0, 27'h0, allow, id};
   endfunction

   function automatic logic [63:0] missw(input logic [31:0] w);
      return {w, 32'h0};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present one request for one cycle, then drop valid; outputs are then sampled by the caller.
   task automatic issue(input logic [31:0] w);
      s_valid = 1'b1;
      s_data  = w;
      cyc();
      s_valid = 1'b0;
   endtask

   task automatic refill(input logic [5:0] sdid, input logic [19:0] ppn, input logic [2:0] perm);
      r_valid = 1'b1;
      r_sdid  = sdid;
      r_ppn   = ppn;
      r_perm  = perm;
      cyc();
      r_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 2'b11;
      r_valid = 1'b0; r_sdid = '0; r_ppn = '0; r_perm = '0;
      cyc(); cyc();
      rst = 1'b0;
      #1;
      total++; if (m_valid !== 2'b00) $display("FAIL reset_valid got=%b exp=00", m_valid); else passed++;
      total++; if (m_data !== 64'h0) $display("FAIL reset_data got=%h exp=0", m_data); else passed++;
      total++; if (s_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", s_ready); else passed++;
   endtask

   task automatic test_miss();
      logic [31:0] w;
      w = mk(2'b00, 6'd1, 20'h00010, 4'd3);
      issue(w);
      total++; if (m_valid !== 2'b10) $display("FAIL miss_valid got=%b exp=10", m_valid); else passed++;
      total++; if (m_data !== missw(w)) $display("FAIL miss_data got=%h exp=%h", m_data, missw(w)); else passed++;
      total++; if (s_ready !== 1'b1) $display("FAIL miss_ready got=%b exp=1", s_ready); else passed++;
      cyc();
      total++; if (m_valid !== 2'b00) $display("FAIL miss_drain got=%b exp=00", m_valid); else passed++;
   endtask

   task automatic test_hit();
      refill(6'd1, 20'h00010, 3'b001);
      issue(mk(2'b00, 6'd1, 20'h00010, 4'd5));
      total++; if (m_valid !== 2'b01) $display("FAIL hit_r_valid got=%b exp=01", m_valid); else passed++;
      total++; if (m_data !== hitw(1'b1, 4'd5)) $display("FAIL hit_r_data got=%h exp=%h", m_data, hitw(1'b1, 4'd5)); else passed++;
      issue(mk(2'b01, 6'd1, 20'h00010, 4'd5));
      total++; if (m_data !== hitw(1'b0, 4'd5)) $display("FAIL hit_w_data got=%h exp=%h", m_data, hitw(1'b0, 4'd5)); else passed++;
      issue(mk(2'b11, 6'd1, 20'h00010, 4'd6));
      total++; if (m_valid !== 2'b01 || m_data !== hitw(1'b0, 4'd6))
         $display("FAIL hit_rsv got=%b/%h exp=01/%h", m_valid, m_data, hitw(1'b0, 4'd6)); else passed++;
      cyc();
   endtask

   task automatic test_evict();
      logic [31:0] w;
      flush = 1'b1; cyc(); flush = 1'b0;
      for (int k = 0; k < 8; k++) refill(6'd2, 20'(k), 3'b111);
      refill(6'd2, 20'd8, 3'b111);
      w = mk(2'b00, 6'd2, 20'd0, 4'd1);
      issue(w);
      total++; if (m_valid !== 2'b10 || m_data !== missw(w))
         $display("FAIL evict_old got=%b/%h exp=10/%h", m_valid, m_data, missw(w)); else passed++;
      issue(mk(2'b00, 6'd2, 20'd8, 4'd2));
      total++; if (m_valid !== 2'b01 || m_data !== hitw(1'b1, 4'd2))
         $display("FAIL evict_new got=%b/%h exp=01/%h", m_valid, m_data, hitw(1'b1, 4'd2)); else passed++;
      refill(6'd2, 20'd9, 3'b111);
      w = mk(2'b00, 6'd2, 20'd1, 4'd3);
      issue(w);
      total++; if (m_valid !== 2'b10) $display("FAIL evict_ptr1 got=%b exp=10", m_valid); else passed++;
      issue(mk(2'b00, 6'd2, 20'd8, 4'd4));
      total++; if (m_valid !== 2'b01) $display("FAIL evict_keep got=%b exp=01", m_valid); else passed++;
      cyc();
   endtask

   task automatic test_update();
      refill(6'd2, 20'd8, 3'b010);
      issue(mk(2'b01, 6'd2, 20'd8, 4'd7));
      total++; if (m_data !== hitw(1'b1, 4'd7)) $display("FAIL upd_w got=%h exp=%h", m_data, hitw(1'b1, 4'd7)); else passed++;
      issue(mk(2'b00, 6'd2, 20'd8, 4'd8));
      total++; if (m_data !== hitw(1'b0, 4'd8)) $display("FAIL upd_r got=%h exp=%h", m_data, hitw(1'b0, 4'd8)); else passed++;
      refill(6'd2, 20'd10, 3'b111);
      issue(mk(2'b00, 6'd2, 20'd2, 4'd9));
      total++; if (m_valid !== 2'b10) $display("FAIL upd_ptr_evict got=%b exp=10", m_valid); else passed++;
      issue(mk(2'b00, 6'd2, 20'd3, 4'd9));
      total++; if (m_valid !== 2'b01) $display("FAIL upd_ptr_keep got=%b exp=01", m_valid); else passed++;
      cyc();
   endtask

   task automatic test_back_to_back();
      logic [31:0] wc;
      m_ready = 2'b10;
      issue(mk(2'b00, 6'd2, 20'd3, 4'd1));
      s_valid = 1'b1;
      s_data  = mk(2'b01, 6'd2, 20'd4, 4'd2);
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (m_valid !== 2'b01 || m_data !== hitw(1'b1, 4'd1) || s_ready !== 1'b0)
            $display("FAIL stall_hold c=%0d got=%b/%h/%b exp=01/%h/0", c, m_valid, m_data, s_ready, hitw(1'b1, 4'd1));
         else passed++;
         cyc();
      end
      m_ready = 2'b11;
      #1;
      total++; if (s_ready !== 1'b1) $display("FAIL stall_release got=%b exp=1", s_ready); else passed++;
      cyc();
      wc = mk(2'b00, 6'd9, 20'd100, 4'd3);
      s_data = wc;
      total++; if (m_valid !== 2'b01 || m_data !== hitw(1'b1, 4'd2))
         $display("FAIL b2b_first got=%b/%h exp=01/%h", m_valid, m_data, hitw(1'b1, 4'd2)); else passed++;
      cyc();
      s_valid = 1'b0;
      total++; if (m_valid !== 2'b10 || m_data !== missw(wc))
         $display("FAIL b2b_second got=%b/%h exp=10/%h", m_valid, m_data, missw(wc)); else passed++;
      cyc();
      total++; if (m_valid !== 2'b00) $display("FAIL b2b_drain got=%b exp=00", m_valid); else passed++;
   endtask

   task automatic test_flush();
      logic [31:0] w;
      logic [31:0] wn;
      w = mk(2'b00, 6'd2, 20'd3, 4'd6);
      flush = 1'b1;
      r_valid = 1'b1; r_sdid = 6'd3; r_ppn = 20'd50; r_perm = 3'b111;
      issue(w);
      flush = 1'b0; r_valid = 1'b0;
      total++; if (m_valid !== 2'b01 || m_data !== hitw(1'b1, 4'd6))
         $display("FAIL flush_same got=%b/%h exp=01/%h", m_valid, m_data, hitw(1'b1, 4'd6)); else passed++;
      issue(w);
      total++; if (m_valid !== 2'b10 || m_data !== missw(w))
         $display("FAIL flush_after got=%b/%h exp=10/%h", m_valid, m_data, missw(w)); else passed++;
      wn = mk(2'b00, 6'd3, 20'd50, 4'd7);
      issue(wn);
      total++; if (m_valid !== 2'b10) $display("FAIL flush_refill_drop got=%b exp=10", m_valid); else passed++;
      cyc();
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      m_ready = 2'b00;
      w = mk(2'b10, 6'd4, 20'd77, 4'd9);
      issue(w);
      total++; if (m_valid !== 2'b10) $display("FAIL rmid_held got=%b exp=10", m_valid); else passed++;
      rst = 1'b1; cyc(); rst = 1'b0;
      total++; if (m_valid !== 2'b00 || m_data !== 64'h0)
         $display("FAIL rmid_clear got=%b/%h exp=00/0", m_valid, m_data); else passed++;
      m_ready = 2'b11;
   endtask

   initial begin
      test_reset();
      test_miss();
      test_hit();
      test_evict();
      test_update();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
